edge_rate_counter: RTL and testbench

//  Consumes the 1-bit toggling output of the negator stage and measures its edge

---
 rtl/edge_rate_counter_if.sv | 11 +
 rtl/edge_rate_counter.sv | 106 ++++++++++
 tb/tb_edge_rate_counter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/edge_rate_counter_if.sv
// Result channel of the edge rate counter: count word with valid/ready handshake.
interface edge_rate_counter_if #(
  parameter int CW = 8
);
  logic [CW-1:0] count_data;
  logic          count_valid;
  logic          count_ready;

  modport master (output count_data, output count_valid, input count_ready);
  modport slave  (input count_data, input count_valid, output count_ready);
endinterface

// File: rtl/edge_rate_counter.sv
// Counts selected edges of `in` over back-to-back WINDOW-cycle windows; first result WINDOW+2 edges after enable.
// Results wait in a one-deep output register; an unconsumed result is overwritten and flagged on dropped.
module edge_rate_counter #(
  parameter int CW     = 8,
  parameter int WINDOW = 16,
  parameter int EDGE   = 0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 in,
  edge_rate_counter_if.master  count,
  output logic                 dropped,
  output logic                 busy
);

  localparam int WW = $clog2(WINDOW);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARM   = 2'd1;
  localparam logic [1:0] COUNT = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          in_d;
  logic [CW-1:0] edge_cnt;
  logic [WW-1:0] win_cnt;

  logic          rise;
  logic          fall;
  logic          hit;
  logic [CW-1:0] cnt_sum;
  logic          win_end;
  logic          publish;
  logic          transfer;

  always_comb begin
    rise     = in & ~in_d;
    fall     = ~in & in_d;
    hit      = (EDGE == 0) ? rise : ((EDGE == 1) ? fall : (rise | fall));
    // saturate instead of wrapping so a fast input reads as "at least max"
    cnt_sum  = (hit && (edge_cnt != CNT_MAX)) ? edge_cnt + 1'b1 : edge_cnt;
    win_end  = (state == COUNT) && (win_cnt == WIN_LAST);
    publish  = win_end && enable;
    transfer = count.count_valid && count.count_ready;

    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = enable ? ARM : IDLE;
      ARM:     state_nxt = enable ? COUNT : IDLE;
      COUNT:   state_nxt = enable ? COUNT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      busy              <= 1'b0;
      in_d              <= 1'b0;
      edge_cnt          <= '0;
      win_cnt           <= '0;
      count.count_data  <= '0;
      count.count_valid <= 1'b0;
      dropped           <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);

      case (state)
        ARM: begin
          // reference sample only; the first window starts on the next cycle
          in_d     <= in;
          edge_cnt <= '0;
          win_cnt  <= '0;
          dropped  <= 1'b0;
        end
        COUNT: begin
          if (enable) begin
            in_d <= in;
            if (win_end) begin
              edge_cnt <= '0;
              win_cnt  <= '0;
            end else begin
              edge_cnt <= cnt_sum;
              win_cnt  <= win_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (publish) begin
        count.count_data  <= cnt_sum;
        count.count_valid <= 1'b1;
        if (count.count_valid && !count.count_ready)
          dropped <= 1'b1;
      end else if (transfer) begin
        count.count_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_edge_rate_counter.sv
// Directed bench: four counter variants (rising, falling, both, 3-bit saturating) share one stimulus.
module tb_edge_rate_counter;

  logic clock;
  logic reset_n;
  logic enable;
  logic sig;
  logic tog;
  logic dropped0, dropped1, dropped2, dropped3;
  logic busy0, busy1, busy2, busy3;
  int   n_cmp;
  int   n_err;

  edge_rate_counter_if #(.CW(8)) if0 ();
  edge_rate_counter_if #(.CW(8)) if1 ();
  edge_rate_counter_if #(.CW(8)) if2 ();
  edge_rate_counter_if #(.CW(3)) if3 ();

  edge_rate_counter #(.CW(8), .WINDOW(16), .EDGE(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .in(sig),
    .count(if0), .dropped(dropped0), .busy(busy0));
  edge_rate_counter #(.CW(8), .WINDOW(16), .EDGE(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .in(sig),
    .count(if1), .dropped(dropped1), .busy(busy1));
  edge_rate_counter #(.CW(8), .WINDOW(16), .EDGE(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .in(sig),
    .count(if2), .dropped(dropped2), .busy(busy2));
  edge_rate_counter #(.CW(3), .WINDOW(16), .EDGE(2)) dut3 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .in(sig),
    .count(if3), .dropped(dropped3), .busy(busy3));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // input changes before each edge so consecutive samples differ while toggling
  task automatic tick();
    if (tog) sig = ~sig;
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    enable  = 1'b0;
    sig     = 1'b0;
    tog     = 1'b0;
    if0.count_ready = 1'b1;
    if1.count_ready = 1'b1;
    if2.count_ready = 1'b1;
    if3.count_ready = 1'b1;

    ticks(3);
    chk("rst_data", 32'(if0.count_data), 0);
    chk("rst_valid", 32'(if0.count_valid), 0);
    chk("rst_dropped", 32'(dropped0), 0);
    chk("rst_busy", 32'(busy0), 0);
    reset_n = 1'b1;
    ticks(2);
    chk("idle_busy", 32'(busy0), 0);

    // window 1 and 2: toggling every clock, ready high
    tog    = 1'b1;
    enable = 1'b1;
    tick();                                   // edge k
    chk("arm_busy", 32'(busy0), 1);
    ticks(16);                                // edge k+16
    chk("pre_first_valid", 32'(if0.count_valid), 0);
    tick();                                   // edge k+17
    chk("w1_valid", 32'(if0.count_valid), 1);
    chk("w1_rise", 32'(if0.count_data), 8);
    chk("w1_fall", 32'(if1.count_data), 8);
    chk("w1_both", 32'(if2.count_data), 16);
    chk("w1_sat", 32'(if3.count_data), 7);
    chk("w1_sat_valid", 32'(if3.count_valid), 1);
    tick();                                   // edge k+18
    chk("w1_consumed", 32'(if0.count_valid), 0);
    ticks(14);                                // edge k+32
    chk("w2_pre_valid", 32'(if0.count_valid), 0);
    tick();                                   // edge k+33
    chk("w2_valid", 32'(if0.count_valid), 1);
    chk("w2_rise", 32'(if0.count_data), 8);

    // window 3: constant input, result held then taken exactly on publish edge
    if0.count_ready = 1'b0;
    tog = 1'b0;
    ticks(15);                                // edge k+48
    chk("w2_hold_valid", 32'(if0.count_valid), 1);
    chk("w2_hold_data", 32'(if0.count_data), 8);
    if0.count_ready = 1'b1;
    tick();                                   // edge k+49
    chk("w3_xfer_pub_valid", 32'(if0.count_valid), 1);
    chk("w3_const_rise", 32'(if0.count_data), 0);
    chk("w3_const_both", 32'(if2.count_data), 0);
    chk("w3_const_sat", 32'(if3.count_data), 0);
    chk("w3_no_drop", 32'(dropped0), 0);

    // window 4: toggling, ready low -> overwrite and drop
    if0.count_ready = 1'b0;
    tog = 1'b1;
    ticks(15);                                // edge k+64
    chk("w3_hold_data", 32'(if0.count_data), 0);
    chk("w3_hold_drop", 32'(dropped0), 0);
    tick();                                   // edge k+65
    chk("w4_valid", 32'(if0.count_valid), 1);
    chk("w4_overwrite", 32'(if0.count_data), 8);
    chk("w4_dropped", 32'(dropped0), 1);
    chk("w4_both", 32'(if2.count_data), 16);
    chk("w4_other_no_drop", 32'(dropped2), 0);
    if0.count_ready = 1'b1;
    tick();                                   // edge k+66
    chk("w4_consumed", 32'(if0.count_valid), 0);
    chk("w4_drop_sticky", 32'(dropped0), 1);

    // enable low mid-window: back to idle, partial window discarded
    ticks(4);
    enable = 1'b0;
    tick();
    chk("dis_busy", 32'(busy0), 0);
    ticks(20);
    chk("dis_no_pub", 32'(if0.count_valid), 0);
    chk("dis_data_kept", 32'(if0.count_data), 8);
    chk("dis_drop_sticky", 32'(dropped0), 1);

    // re-enable: clean restart, dropped cleared on entry to ARM
    enable = 1'b1;
    tick();                                   // edge j
    chk("re_busy", 32'(busy0), 1);
    tick();                                   // edge j+1
    chk("re_drop_clr", 32'(dropped0), 0);
    ticks(15);                                // edge j+16
    chk("re_pre_valid", 32'(if0.count_valid), 0);
    tick();                                   // edge j+17
    chk("re_valid", 32'(if0.count_valid), 1);
    chk("re_rise", 32'(if0.count_data), 8);

    // asynchronous reset mid-window with a pending result
    if0.count_ready = 1'b0;
    ticks(5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_data", 32'(if0.count_data), 0);
    chk("arst_valid", 32'(if0.count_valid), 0);
    chk("arst_busy", 32'(busy0), 0);
    chk("arst_dropped", 32'(dropped0), 0);
    tick();
    reset_n = 1'b1;
    tick();                                   // edge k'
    chk("rr_busy", 32'(busy0), 1);
    ticks(16);                                // edge k'+16
    chk("rr_pre_valid", 32'(if0.count_valid), 0);
    tick();                                   // edge k'+17
    chk("rr_valid", 32'(if0.count_valid), 1);
    chk("rr_rise", 32'(if0.count_data), 8);
    chk("rr_both", 32'(if2.count_data), 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
